// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth multiplier arbiter.
package booth_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    // Arbiter FSM encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Index width for n items; never less than one bit.
    function automatic int unsigned clog2_f(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches upward from last_i+1 with wrap.
module rr_pick
    import booth_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = clog2_f(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] last_i,
    output logic [NREQ-1:0] gnt_c_o,
    output logic [IDXW-1:0] idx_c_o,
    output logic            any_c_o
);

    logic [IDXW-1:0] cand;

    // First requester found after the previous winner takes the grant.
    always_comb begin
        gnt_c_o = '0;
        idx_c_o = '0;
        any_c_o = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDXW'((32'(last_i) + k) % NREQ);
            if (!any_c_o && req_i[cand]) begin
                any_c_o       = 1'b1;
                idx_c_o       = cand;
                gnt_c_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin scheduler sharing one Booth multiplier core among NREQ clients.
module booth_mult_arbiter
    import booth_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid_i,
    output logic [NREQ-1:0]            req_ready_o,
    input  logic [NREQ*WIDTH-1:0]      req_a_i,
    input  logic [NREQ*WIDTH-1:0]      req_b_i,
    output logic [NREQ-1:0]            rsp_valid_o,
    input  logic [NREQ-1:0]            rsp_ready_i,
    output logic [2*WIDTH-1:0]         rsp_prod_o,
    output logic                       rsp_err_o,
    output logic                       mul_clr_o,
    output logic                       mul_start_o,
    output logic [WIDTH-1:0]           mul_a_o,
    output logic [WIDTH-1:0]           mul_b_o,
    input  logic                       mul_done_i,
    input  logic [2*WIDTH-1:0]         mul_prod_i,
    output logic                       busy_o,
    output logic [clog2_f(NREQ)-1:0]   grant_id_o
);

    localparam int unsigned IDXW = clog2_f(NREQ);
    localparam int unsigned WDW  = clog2_f(TIMEOUT);

    state_t             state_q, state_d;
    logic [IDXW-1:0]    last_q, last_d;
    logic [IDXW-1:0]    grant_q, grant_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               err_q, err_d;
    logic [WDW-1:0]     wd_q, wd_d;
    logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic               clr_q, clr_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;

    logic [NREQ-1:0]    pick_gnt;
    logic [IDXW-1:0]    pick_idx;
    logic               pick_any;
    logic [WIDTH-1:0]   sel_a, sel_b;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req_i   (req_valid_i),
        .last_i  (last_q),
        .gnt_c_o (pick_gnt),
        .idx_c_o (pick_idx),
        .any_c_o (pick_any)
    );

    // Operand mux for the round-robin winner.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_idx == IDXW'(i)) begin
                sel_a = req_a_i[i*WIDTH +: WIDTH];
                sel_b = req_b_i[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state, datapath updates and registered-output next values.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        a_d         = a_q;
        b_d         = b_q;
        prod_d      = prod_q;
        err_d       = err_q;
        wd_d        = wd_q;
        req_ready_o = '0;
        rsp_valid_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    req_ready_o = pick_gnt;
                    grant_d     = pick_idx;
                    a_d         = sel_a;
                    b_d         = sel_b;
                    state_d     = ST_CLR;
                end
            end
            ST_CLR: begin
                state_d = ST_START;
            end
            ST_START: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done in the expiry cycle still counts as success.
                if (mul_done_i) begin
                    prod_d  = mul_prod_i;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i[grant_q]) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        for (int unsigned i = 0; i < NREQ; i++) begin
            rsp_valid_d[i] = (state_d == ST_RESP) && (grant_d == IDXW'(i));
        end
        clr_d   = (state_d == ST_CLR);
        start_d = (state_d == ST_START);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= IDXW'(NREQ - 1);
            grant_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            prod_q      <= '0;
            err_q       <= 1'b0;
            wd_q        <= '0;
            rsp_valid_q <= '0;
            clr_q       <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            a_q         <= a_d;
            b_q         <= b_d;
            prod_q      <= prod_d;
            err_q       <= err_d;
            wd_q        <= wd_d;
            rsp_valid_q <= rsp_valid_d;
            clr_q       <= clr_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_prod_o  = prod_q;
    assign rsp_err_o   = err_q;
    assign mul_clr_o   = clr_q;
    assign mul_start_o = start_q;
    assign mul_a_o     = a_q;
    assign mul_b_o     = b_q;
    assign busy_o      = busy_q;
    assign grant_id_o  = grant_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Scoreboard bench for booth_mult_arbiter with a behavioural multiplier core.
module tb_booth_mult_arbiter;
    import booth_pkg::*;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned IDXW    = clog2_f(NREQ);

    typedef struct {
        int unsigned        id;
        logic [2*WIDTH-1:0] prod;
        logic               err;
        int unsigned        lat;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*WIDTH-1:0]  req_a, req_b;
    logic [NREQ-1:0]        rsp_valid;
    logic [NREQ-1:0]        rsp_ready = '1;
    logic [2*WIDTH-1:0]     rsp_prod;
    logic                   rsp_err;
    logic                   mul_clr, mul_start;
    logic [WIDTH-1:0]       mul_a, mul_b;
    logic                   mul_done;
    logic [2*WIDTH-1:0]     mul_prod;
    logic                   busy;
    logic [IDXW-1:0]        grant_id;

    logic [WIDTH-1:0] op_a [NREQ];
    logic [WIDTH-1:0] op_b [NREQ];
    logic [WIDTH-1:0] fix_a [NREQ];
    logic [WIDTH-1:0] fix_b [NREQ];
    bit               use_fix [NREQ];
    bit               taken [NREQ];
    int unsigned      rem [NREQ];
    int unsigned      wait_by_id [NREQ];

    exp_t        sb[$];
    int          grant_log[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          tb_last = NREQ - 1;
    int unsigned cyc = 0;
    int unsigned start_cyc = 0;
    int unsigned wait_cyc = 0;
    int unsigned hold_cnt = 0;
    int unsigned hold_id = 1;
    int unsigned core_lat = 18;
    bit          core_hang = 1'b0;
    bit          acc_d1 = 1'b0, acc_d2 = 1'b0;
    bit          rsp_prev_valid = 1'b0, rsp_hs_prev = 1'b0;
    logic [2*WIDTH-1:0] held_prod, last_prod;
    logic               held_err, last_err;
    logic [WIDTH-1:0]   cur_a, cur_b;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_a[g*WIDTH +: WIDTH] = op_a[g];
        assign req_b[g*WIDTH +: WIDTH] = op_b[g];
    end

    booth_mult_arbiter #(
        .NREQ    (NREQ),
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_prod_o  (rsp_prod),
        .rsp_err_o   (rsp_err),
        .mul_clr_o   (mul_clr),
        .mul_start_o (mul_start),
        .mul_a_o     (mul_a),
        .mul_b_o     (mul_b),
        .mul_done_i  (mul_done),
        .mul_prod_i  (mul_prod),
        .busy_o      (busy),
        .grant_id_o  (grant_id)
    );

    function automatic logic [2*WIDTH-1:0] mul_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] sa, sb2;
        sa  = {{WIDTH{a[WIDTH-1]}}, a};
        sb2 = {{WIDTH{b[WIDTH-1]}}, b};
        return sa * sb2;
    endfunction

    function automatic int rr_ref(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= int'(NREQ); k++) begin
            int c;
            c = (last + k) % int'(NREQ);
            if (v[c]) return c;
        end
        return 0;
    endfunction

    function automatic int idx_of(input logic [NREQ-1:0] v);
        for (int i = 0; i < int'(NREQ); i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Core model: done rises core_lat cycles after start, held until the next clear.
    int unsigned      core_cnt;
    bit               core_act;
    logic [WIDTH-1:0] core_a, core_b;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_done <= 1'b0;
            mul_prod <= '0;
            core_act <= 1'b0;
            core_cnt <= 0;
        end else if (mul_clr) begin
            mul_done <= 1'b0;
            core_act <= 1'b0;
        end else if (mul_start) begin
            core_a   <= mul_a;
            core_b   <= mul_b;
            core_cnt <= core_lat;
            core_act <= !core_hang;
        end else if (core_act) begin
            if (core_cnt <= 1) begin
                mul_done <= 1'b1;
                mul_prod <= mul_ref(core_a, core_b);
                core_act <= 1'b0;
            end
            core_cnt <= core_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic offer(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        fix_a[i]   = a;
        fix_b[i]   = b;
        use_fix[i] = 1'b1;
        rem[i]++;
    endtask

    task automatic monitor();
        logic [NREQ-1:0] hs, oh;
        int              id, win;
        bit              rsp_hs;
        exp_t            e;
        hs     = req_valid & req_ready;
        rsp_hs = 1'b0;
        check("mul_clr", 64'(mul_clr), 64'(acc_d1));
        check("mul_start", 64'(mul_start), 64'(acc_d2));
        if (mul_start) start_cyc = cyc;
        if (rsp_hs_prev) check("idle_after_rsp", {busy, rsp_valid}, '0);
        if (busy && rsp_valid == '0) begin
            check("mul_a_hold", mul_a, cur_a);
            check("mul_b_hold", mul_b, cur_b);
        end
        if (busy || req_valid == '0) begin
            check("req_ready_zero", req_ready, '0);
        end else begin
            win     = rr_ref(req_valid, tb_last);
            oh      = '0;
            oh[win] = 1'b1;
            check("req_ready", req_ready, oh);
        end
        if (hs != '0) begin
            id     = idx_of(hs);
            e.id   = id;
            e.err  = core_hang || (core_lat >= TIMEOUT);
            e.prod = e.err ? '0 : mul_ref(op_a[id], op_b[id]);
            e.lat  = e.err ? TIMEOUT + 1 : core_lat + 2;
            sb.push_back(e);
            grant_log.push_back(id);
            taken[id] = 1'b1;
            cur_a     = op_a[id];
            cur_b     = op_b[id];
        end
        if (rsp_valid != '0) begin
            check("busy_resp", busy, 1);
            if (sb.size() == 0) begin
                check("rsp_spurious", rsp_valid, '0);
            end else begin
                e        = sb[0];
                oh       = '0;
                oh[e.id] = 1'b1;
                check("rsp_valid", rsp_valid, oh);
                check("rsp_grant_id", grant_id, e.id);
                if (!rsp_prev_valid) begin
                    check("rsp_latency", cyc - start_cyc, e.lat);
                    held_prod = rsp_prod;
                    held_err  = rsp_err;
                    wait_cyc  = 0;
                end else begin
                    check("rsp_prod_hold", rsp_prod, held_prod);
                    check("rsp_err_hold", rsp_err, held_err);
                end
                if (rsp_ready[e.id]) begin
                    check("rsp_prod", rsp_prod, e.prod);
                    check("rsp_err", rsp_err, e.err);
                    last_prod        = rsp_prod;
                    last_err         = rsp_err;
                    wait_by_id[e.id] = wait_cyc;
                    tb_last          = e.id;
                    void'(sb.pop_front());
                    rsp_hs = 1'b1;
                end else begin
                    wait_cyc++;
                end
                if (rsp_valid[hold_id] && hold_cnt > 0) hold_cnt--;
            end
        end
        rsp_prev_valid = (rsp_valid != '0) && !rsp_hs;
        rsp_hs_prev    = rsp_hs;
        acc_d2         = acc_d1;
        acc_d1         = (hs != '0);
    endtask

    // One cycle: drive at the falling edge, sample 1 time unit later.
    task automatic step();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (taken[i]) begin
                req_valid[i] = 1'b0;
                taken[i]     = 1'b0;
            end
            if (!req_valid[i] && rem[i] > 0) begin
                op_a[i]      = use_fix[i] ? fix_a[i] : WIDTH'($urandom);
                op_b[i]      = use_fix[i] ? fix_b[i] : WIDTH'($urandom);
                use_fix[i]   = 1'b0;
                req_valid[i] = 1'b1;
                rem[i]--;
            end
        end
        rsp_ready = '1;
        if (hold_cnt > 0) rsp_ready[hold_id] = 1'b0;
        #1;
        monitor();
    endtask

    task automatic drain(input int max_cyc, input string tag);
        bit fin;
        int pend;
        fin = 1'b0;
        for (int n = 0; n < max_cyc && !fin; n++) begin
            step();
            pend = 0;
            for (int i = 0; i < int'(NREQ); i++) pend += int'(rem[i]);
            fin = (sb.size() == 0) && (req_valid == '0) && !busy && (pend == 0);
        end
        check({tag, "_drained"}, 64'(fin), 1);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_req_ready"}, req_ready, '0);
        check({tag, "_rsp_valid"}, rsp_valid, '0);
        check({tag, "_rsp_prod"}, rsp_prod, '0);
        check({tag, "_rsp_err"}, rsp_err, '0);
        check({tag, "_mul_clr"}, mul_clr, '0);
        check({tag, "_mul_start"}, mul_start, '0);
        check({tag, "_mul_a"}, mul_a, '0);
        check({tag, "_mul_b"}, mul_b, '0);
        check({tag, "_busy"}, busy, '0);
        check({tag, "_grant_id"}, grant_id, '0);
    endtask

    task automatic clear_bench();
        sb.delete();
        tb_last        = NREQ - 1;
        req_valid      = '0;
        acc_d1         = 1'b0;
        acc_d2         = 1'b0;
        rsp_prev_valid = 1'b0;
        rsp_hs_prev    = 1'b0;
        core_hang      = 1'b0;
        hold_cnt       = 0;
        for (int i = 0; i < int'(NREQ); i++) begin
            rem[i]     = 0;
            taken[i]   = 1'b0;
            use_fix[i] = 1'b0;
        end
    endtask

    initial begin
        bit fin;
        int fair_exp [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int i = 0; i < int'(NREQ); i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
            wait_by_id[i] = 0;
        end
        clear_bench();
        cur_a = '0;
        cur_b = '0;

        // Reset values.
        repeat (3) step();
        check_reset_outs("reset");
        rst_n = 1'b1;
        step();

        // Fairness with every requester continuously valid.
        grant_log.delete();
        for (int i = 0; i < int'(NREQ); i++) rem[i] = 2;
        drain(1000, "fair");
        check("fair_count", grant_log.size(), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) check("fair_order", grant_log[i], fair_exp[i]);

        // Single request; core done still high from the previous run.
        core_lat = 18;
        offer(2, 16'd7, 16'hFFFD);
        drain(200, "single");
        check("single_prod", last_prod, 32'hFFFF_FFEB);
        check("single_err", last_err, 0);

        // Response backpressure on requester 1 with another requester waiting.
        hold_id  = 1;
        hold_cnt = 10;
        offer(1, 16'h1234, 16'h8001);
        fin = 1'b0;
        for (int n = 0; n < 10 && !fin; n++) begin
            step();
            fin = busy;
        end
        check("bp_busy", 64'(fin), 1);
        offer(3, 16'h7FFF, 16'h7FFF);
        drain(300, "bp");
        check("bp_wait", wait_by_id[1], 10);

        // Watchdog: hung core, done at expiry, done one cycle late.
        core_hang = 1'b1;
        offer(0, 16'd5, 16'd9);
        drain(300, "wd_hang");
        check("wd_hang_err", last_err, 1);
        core_hang = 1'b0;
        core_lat  = TIMEOUT - 1;
        offer(2, 16'h8000, 16'h8000);
        drain(300, "wd_coinc");
        check("wd_coinc_prod", last_prod, 32'h4000_0000);
        core_lat = TIMEOUT;
        offer(3, 16'd100, 16'hFF9C);
        drain(300, "wd_late");
        check("wd_late_err", last_err, 1);
        core_lat = 18;

        // Async reset in WAIT aborts the grant; requester 0 wins first afterwards.
        offer(0, 16'd3, 16'd4);
        drain(200, "pre_rst");
        core_hang = 1'b1;
        offer(1, 16'd11, 16'd13);
        fin = 1'b0;
        for (int n = 0; n < 20 && !fin; n++) begin
            step();
            fin = mul_start;
        end
        check("rst_reach_start", 64'(fin), 1);
        repeat (5) step();
        check("rst_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outs("async_rst");
        clear_bench();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();
        grant_log.delete();
        offer(0, 16'd21, 16'hFFFE);
        offer(2, 16'd6, 16'd7);
        drain(300, "post_rst");
        check("post_rst_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("post_rst_first", grant_log[0], 0);
            check("post_rst_second", grant_log[1], 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
